// File: rtl/xcorr_pkg.sv
// xcorr_pkg: shared types and default sizing for the cross-correlator
// sample-buffer controller.
package xcorr_pkg;

  // Read-burst sequencer states
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Default address width (RAM depth 2**12) and burst length
  localparam int XCORR_RM_DEP_DEF  = 12;
  localparam int XCORR_WIN_LEN_DEF = 1024;

endpackage

// File: rtl/xcorr_buf_ctrl_if.sv
// xcorr_buf_ctrl_if: sample/trigger inputs and RAM address / burst status
// outputs of the buffer controller. The controller uses the slave modport,
// the sample source and burst consumer use the master modport.
interface xcorr_buf_ctrl_if
  import xcorr_pkg::*;
#(
  parameter int RM_DEP = XCORR_RM_DEP_DEF
);
  logic              in_valid;
  logic              trig;
  logic [RM_DEP-1:0] count_w;
  logic [RM_DEP-1:0] count_r;
  logic              rd_valid;
  logic              rd_first;
  logic              rd_last;
  logic              busy;
  logic [RM_DEP:0]   fill;
  logic              ovr;

  modport master (
    output in_valid, trig,
    input  count_w, count_r, rd_valid, rd_first, rd_last, busy, fill, ovr
  );

  modport slave (
    input  in_valid, trig,
    output count_w, count_r, rd_valid, rd_first, rd_last, busy, fill, ovr
  );
endinterface

// File: rtl/xcorr_buf_ctrl.sv
// xcorr_buf_ctrl: circular sample-buffer address controller. Writes advance
// count_w on every accepted sample; a trigger replays the newest WIN_LEN
// samples through count_r, with rd_valid/rd_first/rd_last aligned to the
// one-cycle registered RAM read data.
// Optional build macro: XCORR_FILL_GATE_EN -- ignore triggers (without
// flagging ovr) until at least WIN_LEN samples have been stored.
module xcorr_buf_ctrl
  import xcorr_pkg::*;
#(
  parameter int RM_DEP  = XCORR_RM_DEP_DEF,
  parameter int WIN_LEN = XCORR_WIN_LEN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  xcorr_buf_ctrl_if.slave  bus
);

  localparam int                CNT_W    = $clog2(WIN_LEN) + 1;
  localparam logic [RM_DEP-1:0] WIN_ADDR = RM_DEP'(WIN_LEN);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIN_LEN - 1);
  localparam logic [RM_DEP:0]   FILL_MAX = {1'b1, {RM_DEP{1'b0}}};

  state_t            state_reg;
  logic [RM_DEP-1:0] count_w_reg;
  logic [RM_DEP-1:0] count_r_reg;
  logic [RM_DEP-1:0] next_addr_reg;
  logic [RM_DEP:0]   fill_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              busy_reg;
  logic              ovr_reg;
  logic              iss_reg;
  logic              iss_first_reg;
  logic              iss_last_reg;
  logic              rd_valid_reg;
  logic              rd_first_reg;
  logic              rd_last_reg;
  logic              trig_ok;

`ifdef XCORR_FILL_GATE_EN
  localparam logic [RM_DEP:0] FILL_WIN = (RM_DEP + 1)'(WIN_LEN);
  // A burst only makes sense once a full window has been stored
  assign trig_ok = bus.trig && (fill_reg >= FILL_WIN);
`else
  // Unwritten slots are simply read back as whatever the RAM holds
  assign trig_ok = bus.trig;
`endif

  // Write pointer and saturating fill level advance on every accepted sample
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_w_reg <= '0;
      fill_reg    <= '0;
    end else if (bus.in_valid) begin
      count_w_reg <= count_w_reg + 1'b1;
      if (fill_reg != FILL_MAX) begin
        fill_reg <= fill_reg + 1'b1;
      end
    end
  end

  // Burst sequencer: latch start address on trigger, then issue WIN_LEN
  // consecutive read addresses, one per cycle, wrapping naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      count_r_reg   <= '0;
      next_addr_reg <= '0;
      cnt_reg       <= '0;
      busy_reg      <= 1'b0;
      ovr_reg       <= 1'b0;
      iss_reg       <= 1'b0;
      iss_first_reg <= 1'b0;
      iss_last_reg  <= 1'b0;
    end else begin
      iss_reg       <= 1'b0;
      iss_first_reg <= 1'b0;
      iss_last_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (trig_ok) begin
            // count_w before this edge's increment: a sample accepted on
            // the trigger edge is not part of the window
            state_reg     <= BURST;
            busy_reg      <= 1'b1;
            next_addr_reg <= count_w_reg - WIN_ADDR;
            cnt_reg       <= '0;
          end
        end
        BURST: begin
          if (bus.trig) begin
            ovr_reg <= 1'b1;
          end
          count_r_reg   <= next_addr_reg;
          next_addr_reg <= next_addr_reg + 1'b1;
          cnt_reg       <= cnt_reg + 1'b1;
          iss_reg       <= 1'b1;
          iss_first_reg <= (cnt_reg == '0);
          iss_last_reg  <= (cnt_reg == CNT_LAST);
          if (cnt_reg == CNT_LAST) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Read qualifiers trail the issued address by the RAM read latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_reg <= 1'b0;
      rd_first_reg <= 1'b0;
      rd_last_reg  <= 1'b0;
    end else begin
      rd_valid_reg <= iss_reg;
      rd_first_reg <= iss_first_reg;
      rd_last_reg  <= iss_last_reg;
    end
  end

  assign bus.count_w  = count_w_reg;
  assign bus.count_r  = count_r_reg;
  assign bus.fill     = fill_reg;
  assign bus.busy     = busy_reg;
  assign bus.ovr      = ovr_reg;
  assign bus.rd_valid = rd_valid_reg;
  assign bus.rd_first = rd_first_reg;
  assign bus.rd_last  = rd_last_reg;

endmodule

// File: tb/tb_xcorr_buf_ctrl.sv
// tb_xcorr_buf_ctrl: directed bench for xcorr_buf_ctrl. Four instances with
// different sizes share one stimulus stream; each sequence checks the
// instance whose configuration it targets.
module tb_xcorr_buf_ctrl;
  import xcorr_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       trig = 1'b0;
  logic [7:0] wdata = 8'd0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  xcorr_buf_ctrl_if #(.RM_DEP(12)) bus_def ();
  xcorr_buf_ctrl_if #(.RM_DEP(4))  bus_a ();
  xcorr_buf_ctrl_if #(.RM_DEP(4))  bus_b ();
  xcorr_buf_ctrl_if #(.RM_DEP(4))  bus_c ();

  assign bus_def.in_valid = in_valid;
  assign bus_def.trig     = trig;
  assign bus_a.in_valid   = in_valid;
  assign bus_a.trig       = trig;
  assign bus_b.in_valid   = in_valid;
  assign bus_b.trig       = trig;
  assign bus_c.in_valid   = in_valid;
  assign bus_c.trig       = trig;

  xcorr_buf_ctrl u_def (.clk(clk), .rst(rst), .bus(bus_def));
  xcorr_buf_ctrl #(.RM_DEP(4), .WIN_LEN(4)) u_a (.clk(clk), .rst(rst), .bus(bus_a));
  xcorr_buf_ctrl #(.RM_DEP(4), .WIN_LEN(8)) u_b (.clk(clk), .rst(rst), .bus(bus_b));
  xcorr_buf_ctrl #(.RM_DEP(4), .WIN_LEN(1)) u_c (.clk(clk), .rst(rst), .bus(bus_c));

  // Sample RAM behind instance a: writes every cycle, registered read
  logic [7:0] ram_a [16];
  logic [7:0] rd_data_a;
  always @(posedge clk) begin
    ram_a[bus_a.count_w] <= wdata;
    rd_data_a            <= ram_a[bus_a.count_r];
  end

  typedef struct {
    logic       v;
    logic       t;
    logic [7:0] d;
    logic [3:0] cw;
    logic [3:0] cr;
    logic       rv;
    logic       rf;
    logic       rl;
    logic       bsy;
    logic [7:0] data;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    trig     = 1'b0;
    wdata    = 8'd0;
    rst      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Apply inputs for one edge, then settle just after it
  task automatic cyc(input logic v, input logic t, input logic [7:0] d);
    in_valid = v;
    trig     = t;
    wdata    = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rv_b, rv_c, rf_b, rl_b;
    logic [3:0] exp_cr;

    // Table: 10 samples 1..10, trigger, then the 4-sample burst on instance a
    for (int i = 0; i < 10; i++) begin
      tbl[i] = '{1'b1, 1'b0, 8'(i + 1), 4'(i + 1), 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    end
    tbl[10] = '{1'b0, 1'b1, 8'd0, 4'd10, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[11] = '{1'b0, 1'b0, 8'd0, 4'd10, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[12] = '{1'b0, 1'b0, 8'd0, 4'd10, 4'd7, 1'b1, 1'b1, 1'b0, 1'b1, 8'd7};
    tbl[13] = '{1'b0, 1'b0, 8'd0, 4'd10, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1, 8'd8};
    tbl[14] = '{1'b0, 1'b0, 8'd0, 4'd10, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 8'd9};
    tbl[15] = '{1'b0, 1'b0, 8'd0, 4'd10, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0, 8'd10};
    tbl[16] = '{1'b0, 1'b0, 8'd0, 4'd10, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};

    // Reset state, sampled while reset is held
    in_valid = 1'b0;
    trig     = 1'b0;
    rst      = 1'b0;
    #12;
    check("reset_def_outputs",
          {bus_def.count_w, bus_def.count_r, bus_def.fill, bus_def.rd_valid,
           bus_def.rd_first, bus_def.rd_last, bus_def.busy, bus_def.ovr}, 32'd0);

    // 20 samples, no trigger, default-size instance
    do_reset();
    rv_b = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, 8'(i));
      rv_b += int'(bus_def.rd_valid);
    end
    check("def_count_w", 32'(bus_def.count_w), 32'd20);
    check("def_fill", 32'(bus_def.fill), 32'd20);
    check("def_busy", 32'(bus_def.busy), 32'd0);
    check("def_rd_valid_pulses", 32'(rv_b), 32'd0);

    // Table-driven: WIN_LEN=4 burst with RAM data
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].v, tbl[i].t, tbl[i].d);
      check($sformatf("tbl_row%0d", i),
            {bus_a.count_w, bus_a.count_r, bus_a.rd_valid, bus_a.rd_first, bus_a.rd_last, bus_a.busy},
            {tbl[i].cw, tbl[i].cr, tbl[i].rv, tbl[i].rf, tbl[i].rl, tbl[i].bsy});
      if (tbl[i].rv) check($sformatf("tbl_data%0d", i), 32'(rd_data_a), 32'(tbl[i].data));
    end

    // Wrap across the top of the RAM (WIN_LEN=8), sample on the trigger edge
    // excluded, fill saturation, and WIN_LEN=1 first/last coincidence
    do_reset();
    for (int i = 0; i < 18; i++) cyc(1'b1, 1'b0, 8'(i));
    cyc(1'b1, 1'b1, 8'd0);
    check("wrap_count_w", 32'(bus_b.count_w), 32'd3);
    check("wrap_fill_sat", 32'(bus_b.fill), 32'd16);
    check("wrap_busy", 32'(bus_b.busy), 32'd1);
    rv_b = 0; rf_b = 0; rl_b = 0;
    for (int j = 0; j < 10; j++) begin
      cyc(1'b0, 1'b0, 8'd0);
      if (j < 8) begin
        exp_cr = 4'(10 + j);
        check($sformatf("wrap_count_r%0d", j), 32'(bus_b.count_r), 32'(exp_cr));
      end
      rv_b += int'(bus_b.rd_valid);
      rf_b += int'(bus_b.rd_first && bus_b.rd_valid);
      rl_b += int'(bus_b.rd_last && bus_b.rd_valid);
      if (j == 1) check("wrap_first_pos", 32'(bus_b.rd_first), 32'd1);
      if (j == 8) check("wrap_last_pos", 32'(bus_b.rd_last), 32'd1);
      if (j == 0) check("win1_count_r", 32'(bus_c.count_r), 32'd1);
      if (j == 1) check("win1_v_f_l", 32'({bus_c.rd_valid, bus_c.rd_first, bus_c.rd_last}), 32'b111);
      if (j == 2) check("win1_v_after", 32'(bus_c.rd_valid), 32'd0);
    end
    check("wrap_rv_pulses", 32'(rv_b), 32'd8);
    check("wrap_first_cnt", 32'(rf_b), 32'd1);
    check("wrap_last_cnt", 32'(rl_b), 32'd1);
    check("wrap_idle_hold", 32'(bus_b.count_r), 32'd1);

    // Second trigger 3 cycles after the first: dropped while busy
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 8'(i));
    rv_b = 0; rv_c = 0;
    cyc(1'b0, 1'b1, 8'd0);
    check("ovr_pre", 32'(bus_b.ovr), 32'd0);
    for (int j = 0; j < 19; j++) begin
      cyc(1'b0, (j == 2), 8'd0);
      rv_b += int'(bus_b.rd_valid);
      rv_c += int'(bus_c.rd_valid);
    end
    check("ovr_b_set", 32'(bus_b.ovr), 32'd1);
    check("ovr_a_set", 32'(bus_a.ovr), 32'd1);
    check("ovr_c_clear", 32'(bus_c.ovr), 32'd0);
    check("ovr_b_pulses", 32'(rv_b), 32'd8);
    check("ovr_c_pulses", 32'(rv_c), 32'd2);
    check("ovr_b_idle", 32'(bus_b.busy), 32'd0);

    // Asynchronous reset during burst cycle 3
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 8'(i));
    cyc(1'b0, 1'b1, 8'd0);
    for (int j = 0; j < 3; j++) cyc(1'b0, 1'b0, 8'd0);
    check("abort_pre_rv", 32'(bus_b.rd_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("abort_outputs",
          {bus_b.count_w, bus_b.count_r, bus_b.fill, bus_b.rd_valid,
           bus_b.rd_first, bus_b.rd_last, bus_b.busy, bus_b.ovr}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    rv_b = 0;
    for (int j = 0; j < 12; j++) begin
      cyc(1'b0, 1'b0, 8'd0);
      rv_b += int'(bus_b.rd_valid);
    end
    check("abort_no_rv", 32'(rv_b), 32'd0);
    check("abort_busy", 32'(bus_b.busy), 32'd0);

`ifdef XCORR_FILL_GATE_EN
    // Trigger below a full window is ignored without ovr
    do_reset();
    cyc(1'b1, 1'b0, 8'd1);
    cyc(1'b1, 1'b0, 8'd2);
    cyc(1'b0, 1'b1, 8'd0);
    check("gate_low_busy", 32'(bus_a.busy), 32'd0);
    check("gate_low_ovr", 32'(bus_a.ovr), 32'd0);
    cyc(1'b1, 1'b0, 8'd3);
    cyc(1'b1, 1'b0, 8'd4);
    cyc(1'b0, 1'b1, 8'd0);
    check("gate_full_busy", 32'(bus_a.busy), 32'd1);
    cyc(1'b0, 1'b0, 8'd0);
    check("gate_full_start", 32'(bus_a.count_r), 32'd0);
`else
    // Trigger accepted at any fill level; start wraps below zero
    do_reset();
    cyc(1'b1, 1'b0, 8'd1);
    cyc(1'b1, 1'b0, 8'd2);
    cyc(1'b0, 1'b1, 8'd0);
    check("nogate_busy", 32'(bus_a.busy), 32'd1);
    check("nogate_ovr", 32'(bus_a.ovr), 32'd0);
    cyc(1'b0, 1'b0, 8'd0);
    check("nogate_start", 32'(bus_a.count_r), 32'd14);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/xcorr_buf_ctrl.md
XCORR_BUF_CTRL -- requirements
Module: xcorr_buf_ctrl

Interface
REQ-001 SHALL have parameter RM_DEP, default 12: address width, matching the sample RAM depth of 2**RM_DEP.
REQ-002 SHALL have parameter WIN_LEN, default 1024: samples per read burst; legal range 1..2**(RM_DEP-1).
REQ-003 SHALL have port clk, input, 1: single clock.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: the I/Q sample presented to the RAM this cycle is accepted.
REQ-006 SHALL have port trig, input, 1: request a burst of the newest WIN_LEN samples.
REQ-007 SHALL have port count_w, output, RM_DEP: RAM write address.
REQ-008 SHALL have port count_r, output, RM_DEP: RAM read address.
REQ-009 SHALL have port rd_valid, output, 1: RAM read data this cycle belongs to a burst.
REQ-010 SHALL have ports rd_first and rd_last, output, 1 each: first and last burst sample, qualified by rd_valid.
REQ-011 SHALL have port busy, output, 1: burst in progress.
REQ-012 SHALL have port fill, output, RM_DEP+1: count of valid samples stored, saturating at 2**RM_DEP.
REQ-013 SHALL have port ovr, output, 1: sticky flag for a dropped trigger.

Function
REQ-014 count_w SHALL be a register that increments modulo 2**RM_DEP on every edge where in_valid=1; the RAM writes every cycle, so a cycle without in_valid only writes the next free slot, and the next valid sample overwrites it.
REQ-015 fill SHALL increment on each accepted sample and hold at 2**RM_DEP.
REQ-016 The FSM SHALL have two states: IDLE and BURST.
REQ-017 IDLE->BURST SHALL occur on an edge with trig=1; start address = count_w - WIN_LEN mod 2**RM_DEP, taken from count_w before that edge's increment.
REQ-018 A sample accepted on the trigger edge SHALL be excluded from that burst.
REQ-019 In BURST, count_r SHALL step +1 modulo 2**RM_DEP per cycle for exactly WIN_LEN addresses, then return to IDLE, deasserting busy.
REQ-020 The burst SHALL wrap across address 2**RM_DEP-1 -> 0 with no gap.
REQ-021 In IDLE, count_r SHALL hold its last value.
REQ-022 rd_valid, rd_first and rd_last SHALL lag count_r by one cycle, matching the one-cycle registered RAM read latency.
REQ-023 Trigger edge k SHALL give the first rd_valid after edge k+2; WIN_LEN consecutive rd_valid cycles follow.
REQ-024 When WIN_LEN=1, rd_first and rd_last SHALL both assert in the same cycle.
REQ-025 busy SHALL be 1 from edge k until the last address is issued.
REQ-026 A trig arriving while busy=1 SHALL be ignored and SHALL set ovr; ovr clears only on reset.
REQ-027 Writes SHALL continue unaffected during a burst.
REQ-028 Because WIN_LEN <= 2**(RM_DEP-1), a burst SHALL NOT read a slot overwritten after the trigger unless more than 2**(RM_DEP-1) samples arrive during the burst; that case is outside the legal operating range.

Reset
REQ-029 On rst=0, all state SHALL clear asynchronously: count_w=0, count_r=0, fill=0, FSM=IDLE, rd_valid=rd_first=rd_last=busy=ovr=0.
REQ-030 Reset mid-burst SHALL abort the burst with no further rd_valid pulses.
REQ-031 Reset release SHALL be synchronised by the instantiating level; outputs SHALL respond to rst=1 from the next clk edge.

Configuration
REQ-032 With XCORR_FILL_GATE_EN defined, a trigger SHALL be ignored without setting ovr while fill < WIN_LEN.
REQ-033 Without XCORR_FILL_GATE_EN, a trigger SHALL always be accepted in IDLE, and unwritten slots are read as-is.

Structure
REQ-034 A shared package xcorr_pkg SHALL hold the FSM state typedef (IDLE, BURST) and the default RM_DEP/WIN_LEN constants.
REQ-035 SHALL be a single module with no sub-modules; the burst counter is log2(WIN_LEN)+1 bits wide.

Verification
REQ-036 Reset, then 20 valid samples with no trigger -> count_w=20, fill=20, busy=0, rd_valid never asserted.
REQ-037 RM_DEP=4, WIN_LEN=4, 10 samples (values 1..10), trig -> count_r sequence 6,7,8,9; rd_valid four cycles starting two edges after trig; data 7,8,9,10; rd_first on 7, rd_last on 10.
REQ-038 RM_DEP=4, WIN_LEN=8, 18 samples, trig -> count_r 10..15,0,1 with wrap and no gap.
REQ-039 trig twice, 3 cycles apart, WIN_LEN=8 -> second trig dropped, ovr=1, exactly 8 rd_valid pulses.
REQ-040 rst asserted at burst cycle 3 -> all outputs 0 immediately, no rd_valid after release.
REQ-041 XCORR_FILL_GATE_EN defined, fill=2, WIN_LEN=4, trig -> ignored, ovr=0; repeat at fill=4 -> burst runs.
